// File: rtl/leaf_out_arbiter_pkg.sv
// Shared definitions for the leaf output arbiter: packet width default,
// valid-bit position and the arbiter state encoding.
package leaf_pkg;

    localparam int DEF_PACKET_BITS = 49;
    localparam int DEF_VALID_BIT   = DEF_PACKET_BITS - 1;

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } arb_state_t;

endpackage

// File: rtl/leaf_out_arbiter_if.sv
// Bundle between the internal packet sources / BFT link and the arbiter.
// The master side is the sources plus the BFT; the slave side is the arbiter.
interface leaf_out_arbiter_if #(
    parameter int PACKET_BITS = leaf_pkg::DEF_PACKET_BITS,
    parameter int NUM_REQ     = 4
);
    localparam int SEL_BITS = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]             req;
    logic [PACKET_BITS*NUM_REQ-1:0] pkt_in;
    logic [NUM_REQ-1:0]             ack;
    logic [PACKET_BITS-1:0]         dout;
    logic                           resend;
    logic [SEL_BITS-1:0]            owner;
    logic                           busy;

    modport master (
        output req, pkt_in, resend,
        input  ack, dout, owner, busy
    );

    modport slave (
        input  req, pkt_in, resend,
        output ack, dout, owner, busy
    );
endinterface

// File: rtl/leaf_out_arbiter_rr_pick.sv
// Combinational round-robin search: first set bit of req at or after start,
// wrapping. Done as a priority encode over {req, req} with everything below
// start masked off, so the upper copy supplies the wrapped-around candidates.
module rr_pick #(
    parameter int NUM_REQ  = 4,
    parameter int SEL_BITS = 2
) (
    input  logic [NUM_REQ-1:0]  req,
    input  logic [SEL_BITS-1:0] start,
    output logic                found,
    output logic [SEL_BITS-1:0] idx
);
    logic [2*NUM_REQ-1:0] dbl;
    logic [2*NUM_REQ-1:0] keep_mask;
    logic [2*NUM_REQ-1:0] masked;

    assign dbl = {req, req};

    generate
        for (genvar gi = 0; gi < 2*NUM_REQ; gi++) begin : g_mask
            assign keep_mask[gi] = (gi >= int'(start));
        end
    endgenerate

    assign masked = dbl & keep_mask;

    // Lowest surviving bit wins; scanning downward lets the last hit stand.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int i = 2*NUM_REQ-1; i >= 0; i--) begin
            if (masked[i]) begin
                found = 1'b1;
                idx   = SEL_BITS'(i % NUM_REQ);
            end
        end
    end
endmodule

// File: rtl/leaf_out_arbiter.sv
// Round-robin, burst-limited arbiter sharing one BFT output link among
// several internal packet sources. Winner gets a same-cycle ack and its
// packet is registered onto dout; a resend on a valid dout freezes everything.
module leaf_out_arbiter
    import leaf_pkg::*;
#(
    parameter int PACKET_BITS = DEF_PACKET_BITS,
    parameter int NUM_REQ     = 4,
    parameter int BURST_LEN   = 8
) (
    input  logic             clk,
    input  logic             reset,
    leaf_out_arbiter_if.slave bus
);
    localparam int SEL_BITS  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_BITS  = $clog2(BURST_LEN + 1);
    localparam int VALID_BIT = PACKET_BITS - 1;

    arb_state_t             state_reg;
    logic [SEL_BITS-1:0]    owner_reg;
    logic [SEL_BITS-1:0]    rr_ptr_reg;
    logic [CNT_BITS-1:0]    burst_cnt_reg;
    logic [PACKET_BITS-1:0] dout_reg;

    logic                   hold;
    logic                   keep;
    logic                   grant;
    logic                   pick_found;
    logic [SEL_BITS-1:0]    pick_idx;
    logic [SEL_BITS-1:0]    win_idx;
    logic [SEL_BITS-1:0]    rr_ptr_next;
    logic [PACKET_BITS-1:0] win_pkt;
    logic [NUM_REQ-1:0]     ack_vec;

    // rr_ptr always sits at last winner + 1, so an expired or released owner
    // naturally searches from owner + 1.
    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .SEL_BITS(SEL_BITS)
    ) u_rr_pick (
        .req  (bus.req),
        .start(rr_ptr_reg),
        .found(pick_found),
        .idx  (pick_idx)
    );

    assign hold  = bus.resend && dout_reg[VALID_BIT];
    assign keep  = (state_reg == OWN) && bus.req[owner_reg]
                   && (burst_cnt_reg < CNT_BITS'(BURST_LEN));
    assign grant = !reset && !hold && (keep || pick_found);

    assign win_idx     = keep ? owner_reg : pick_idx;
    assign win_pkt     = bus.pkt_in[int'(win_idx)*PACKET_BITS +: PACKET_BITS];
    assign rr_ptr_next = (pick_idx == SEL_BITS'(NUM_REQ - 1)) ? '0
                                                              : pick_idx + SEL_BITS'(1);

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ack
            assign ack_vec[gi] = grant && (win_idx == SEL_BITS'(gi));
        end
    endgenerate

    assign bus.ack   = ack_vec;
    assign bus.dout  = dout_reg;
    assign bus.owner = owner_reg;
    assign bus.busy  = (state_reg == OWN);

    // Arbitration state machine and output register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            owner_reg     <= '0;
            rr_ptr_reg    <= '0;
            burst_cnt_reg <= '0;
            dout_reg      <= '0;
        end else if (hold) begin
            // BFT rejected the packet: replay it unchanged.
        end else if (keep) begin
            burst_cnt_reg <= burst_cnt_reg + CNT_BITS'(1);
            dout_reg      <= win_pkt;
        end else if (pick_found) begin
            state_reg     <= OWN;
            owner_reg     <= pick_idx;
            burst_cnt_reg <= CNT_BITS'(1);
            rr_ptr_reg    <= rr_ptr_next;
            dout_reg      <= win_pkt;
        end else begin
            state_reg <= IDLE;
            dout_reg  <= '0;
        end
    end
endmodule

// File: tb/tb_leaf_out_arbiter.sv
// Directed self-checking bench for leaf_out_arbiter (4 ports, 49-bit packets,
// burst length 8). Inputs change 1 ns after the rising edge; ack is checked
// mid-cycle and registered outputs right after the following edge.
module tb_leaf_out_arbiter;
    localparam int PB = 49;
    localparam int NR = 4;
    localparam int BL = 8;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    leaf_out_arbiter_if #(.PACKET_BITS(PB), .NUM_REQ(NR)) bus ();

    leaf_out_arbiter #(
        .PACKET_BITS(PB),
        .NUM_REQ    (NR),
        .BURST_LEN  (BL)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [PB-1:0] pk(input int port, input int n);
        return {1'b1, 8'(port), 40'(n)};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_slot(input int port, input logic [PB-1:0] v);
        bus.pkt_in[port*PB +: PB] = v;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_port;
        total      = 0;
        bad        = 0;
        reset      = 1'b1;
        bus.resend = 1'b0;
        bus.req    = 4'b1111;
        bus.pkt_in = '0;
        for (int i = 0; i < NR; i++) set_slot(i, pk(i, 1));

        // Reset: ack forced low even with every port requesting.
        #3;
        chk("reset_ack", 64'(bus.ack), 64'(4'b0000));
        tick();
        tick();
        reset   = 1'b0;
        bus.req = 4'b0000;
        chk("reset_dout", 64'(bus.dout), 64'd0);
        chk("reset_owner", 64'(bus.owner), 64'd0);
        chk("reset_busy", 64'(bus.busy), 64'd0);

        // Single requester on port 2 for 10 packets, rotating onto itself.
        bus.req = 4'b0100;
        for (int k = 0; k < 10; k++) begin
            set_slot(2, pk(2, k));
            #3;
            chk($sformatf("single_ack%0d", k), 64'(bus.ack), 64'(4'b0100));
            tick();
            chk($sformatf("single_dout%0d", k), 64'(bus.dout), 64'(pk(2, k)));
            chk($sformatf("single_owner%0d", k), 64'(bus.owner), 64'd2);
            chk($sformatf("single_burst%0d", k), 64'(dut.burst_cnt_reg), 64'((k % 8) + 1));
        end
        bus.req = 4'b0000;
        #3;
        chk("single_idle_ack", 64'(bus.ack), 64'd0);
        tick();
        chk("single_idle_dout", 64'(bus.dout), 64'd0);
        chk("single_idle_busy", 64'(bus.busy), 64'd0);
        chk("single_idle_owner", 64'(bus.owner), 64'd2);

        // Two requesters: 8 to port 0, 8 to port 1, 8 to port 0.
        bus.req = 4'b0011;
        for (int k = 0; k < 24; k++) begin
            exp_port = (k >= 8 && k < 16) ? 1 : 0;
            set_slot(0, pk(0, k));
            set_slot(1, pk(1, k));
            #3;
            chk($sformatf("two_ack%0d", k), 64'(bus.ack), 64'(1 << exp_port));
            tick();
            chk($sformatf("two_dout%0d", k), 64'(bus.dout), 64'(pk(exp_port, k)));
        end
        bus.req = 4'b0000;
        tick();
        chk("two_idle_dout", 64'(bus.dout), 64'd0);

        // Resend hold: P stays on dout for 4 cycles, no ack while held.
        bus.req = 4'b0010;
        set_slot(1, pk(1, 100));
        #3;
        chk("rs_first_ack", 64'(bus.ack), 64'(4'b0010));
        tick();
        chk("rs_first_dout", 64'(bus.dout), 64'(pk(1, 100)));
        set_slot(1, pk(1, 101));
        bus.resend = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #3;
            chk($sformatf("rs_hold_ack%0d", k), 64'(bus.ack), 64'd0);
            tick();
            chk($sformatf("rs_hold_dout%0d", k), 64'(bus.dout), 64'(pk(1, 100)));
        end
        bus.resend = 1'b0;
        #3;
        chk("rs_next_ack", 64'(bus.ack), 64'(4'b0010));
        tick();
        chk("rs_next_dout", 64'(bus.dout), 64'(pk(1, 101)));
        bus.req = 4'b0000;
        tick();
        chk("rs_idle_dout", 64'(bus.dout), 64'd0);

        // Resend while dout is invalid is ignored.
        bus.resend = 1'b1;
        bus.req    = 4'b0010;
        set_slot(1, pk(1, 200));
        #3;
        chk("rsinv_ack", 64'(bus.ack), 64'(4'b0010));
        tick();
        chk("rsinv_dout", 64'(bus.dout), 64'(pk(1, 200)));
        bus.resend = 1'b0;
        bus.req    = 4'b0000;
        tick();

        // All four from reset, each dropping after its ack: order 0,1,2,3.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < NR; i++) set_slot(i, pk(i, 300 + i));
        for (int i = 0; i < NR; i++) begin
            bus.req = 4'(4'b1111 << i);
            #3;
            chk($sformatf("all_ack%0d", i), 64'(bus.ack), 64'(1 << i));
            tick();
            chk($sformatf("all_dout%0d", i), 64'(bus.dout), 64'(pk(i, 300 + i)));
        end
        bus.req = 4'b0001;
        set_slot(0, pk(0, 400));
        #3;
        chk("all_next_ack", 64'(bus.ack), 64'(4'b0001));
        tick();
        chk("all_next_dout", 64'(bus.dout), 64'(pk(0, 400)));
        bus.req = 4'b0000;
        tick();

        // Reset mid-burst of port 3, then search restarts from port 0.
        bus.req = 4'b1000;
        for (int k = 0; k < 4; k++) begin
            set_slot(3, pk(3, 500 + k));
            #3;
            chk($sformatf("mid_ack%0d", k), 64'(bus.ack), 64'(4'b1000));
            tick();
            chk($sformatf("mid_dout%0d", k), 64'(bus.dout), 64'(pk(3, 500 + k)));
        end
        reset = 1'b1;
        #3;
        chk("mid_reset_ack", 64'(bus.ack), 64'd0);
        tick();
        reset = 1'b0;
        chk("mid_reset_dout", 64'(bus.dout), 64'd0);
        chk("mid_reset_busy", 64'(bus.busy), 64'd0);
        bus.req = 4'b1010;
        set_slot(1, pk(1, 600));
        set_slot(3, pk(3, 600));
        #3;
        chk("post_reset_ack", 64'(bus.ack), 64'(4'b0010));
        tick();
        chk("post_reset_dout", 64'(bus.dout), 64'(pk(1, 600)));
        chk("post_reset_owner", 64'(bus.owner), 64'd1);
        bus.req = 4'b0000;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
